// File: rtl/spi_pkg.sv
// spi_pkg: state encoding, frame width helper and opcode bits shared by SPI master and slave.
package spi_pkg;
  typedef enum logic [1:0] {IDLE, CMD, RD_ARMED, RD_SHIFT} spi_state_e;
  localparam logic OP_WR = 1'b1;
  localparam logic OP_RD = 1'b0;
  function automatic int cmd_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction
endpackage

// File: rtl/spi_reg_slave_if.sv
// spi_reg_slave_if: SPI pins plus local register-update and status strobes.
interface spi_reg_slave_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
);
  logic              sclk;
  logic              cs;
  logic              mosi;
  logic              miso;
  logic              reg_wr_vld;
  logic [ADDR_W-1:0] reg_wr_addr;
  logic [DATA_W-1:0] reg_wr_data;
  logic              rd_done;
  logic              frame_err;
  modport master (output sclk, cs, mosi, input miso, reg_wr_vld, reg_wr_addr, reg_wr_data, rd_done, frame_err);
  modport slave  (input sclk, cs, mosi, output miso, reg_wr_vld, reg_wr_addr, reg_wr_data, rd_done, frame_err);
endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer with rise/fall pulses derived from the synced level.
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [STAGES:0] sh;
  always_ff @(posedge clk or posedge rst)
    if (rst) sh <= '0;
    else sh <= {sh[STAGES-1:0], din};
  assign level = sh[STAGES-1];
  assign rise  = sh[STAGES-1] & ~sh[STAGES];
  assign fall  = ~sh[STAGES-1] & sh[STAGES];
endmodule

// File: rtl/spi_reg_slave.sv
// spi_reg_slave: mode-0 SPI register-file responder with write frames and split address/data reads.
module spi_reg_slave import spi_pkg::*; #(
  parameter int ADDR_W      = 3,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic            clk,
  input logic            rst,
  spi_reg_slave_if.slave bus
);
  localparam int CMD_W = cmd_w(ADDR_W, DATA_W);
  localparam int CNT_W = $clog2(CMD_W + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CMD_W + 1);
  spi_state_e state, nstate;
  logic sclk_r, sclk_f, cs_r, cs_f, mosi_s;
  logic [3:0] unused_edges;
  logic [CMD_W-1:0] shreg;
  logic [DATA_W-1:0] tx_shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic [DATA_W-1:0] regs [2**ADDR_W];
  logic is_wr, is_rd, do_wr, do_arm, do_err, do_done, shift_in, count_rd, miso;
  logic reg_wr_vld, rd_done, frame_err;
  logic [ADDR_W-1:0] reg_wr_addr;
  logic [DATA_W-1:0] reg_wr_data;
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (.clk(clk), .rst(rst), .din(bus.sclk), .level(unused_edges[0]), .rise(sclk_r), .fall(sclk_f));
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs   (.clk(clk), .rst(rst), .din(bus.cs), .level(unused_edges[1]), .rise(cs_r), .fall(cs_f));
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_mosi (.clk(clk), .rst(rst), .din(bus.mosi), .level(mosi_s), .rise(unused_edges[2]), .fall(unused_edges[3]));
  assign is_wr = shreg[CMD_W-1] == OP_WR && bit_cnt == CNT_W'(CMD_W);
  assign is_rd = shreg[ADDR_W] == OP_RD && bit_cnt == CNT_W'(1 + ADDR_W);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nstate;
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:     nstate = cs_f ? CMD : IDLE;
      CMD:      nstate = !cs_r ? CMD : is_rd ? RD_ARMED : IDLE;
      RD_ARMED: nstate = cs_f ? RD_SHIFT : RD_ARMED;
      RD_SHIFT: nstate = cs_r ? IDLE : RD_SHIFT;
    endcase
  end
  // A cs rise wins over a coincident sclk rise, so the frame is judged on the prior count.
  always_comb begin
    do_wr    = state == CMD && cs_r && is_wr;
    do_arm   = state == CMD && cs_r && is_rd;
    do_err   = cs_r && ((state == CMD && !is_wr && !is_rd) || (state == RD_SHIFT && bit_cnt != CNT_W'(DATA_W)));
    shift_in = state == CMD && sclk_r && !cs_r;
    count_rd = state == RD_SHIFT && sclk_r && !cs_r;
    do_done  = count_rd && bit_cnt == CNT_W'(DATA_W - 1);
    miso     = state == RD_SHIFT ? tx_shreg[DATA_W-1] : 1'b0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      reg_wr_vld  <= 1'b0;
      rd_done     <= 1'b0;
      frame_err   <= 1'b0;
      reg_wr_addr <= '0;
      reg_wr_data <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      tx_shreg    <= '0;
      for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= '0;
    end else begin
      reg_wr_vld <= do_wr;
      rd_done    <= do_done;
      frame_err  <= do_err;
      if (cs_f && (state == IDLE || state == RD_ARMED)) bit_cnt <= '0;
      else if ((shift_in || count_rd) && bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 1'b1;
      if (cs_f && state == IDLE) shreg <= '0;
      else if (shift_in) shreg <= {shreg[CMD_W-2:0], mosi_s};
      if (do_wr) begin
        regs[shreg[CMD_W-2 -: ADDR_W]] <= shreg[DATA_W-1:0];
        reg_wr_addr <= shreg[CMD_W-2 -: ADDR_W];
        reg_wr_data <= shreg[DATA_W-1:0];
      end
      if (do_arm) tx_shreg <= regs[shreg[ADDR_W-1:0]];
      else if (state == RD_SHIFT && sclk_f) tx_shreg <= {tx_shreg[DATA_W-2:0], 1'b0};
    end
  assign bus.miso        = miso;
  assign bus.reg_wr_vld  = reg_wr_vld;
  assign bus.reg_wr_addr = reg_wr_addr;
  assign bus.reg_wr_data = reg_wr_data;
  assign bus.rd_done     = rd_done;
  assign bus.frame_err   = frame_err;
endmodule

// File: tb/tb_spi_reg_slave.sv
// tb_spi_reg_slave: table vectors, hand-written corner sequences and random frames against a frame-level model.
module tb_spi_reg_slave;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  spi_reg_slave_if #(.ADDR_W(3), .DATA_W(8)) bus();
  spi_reg_slave #(.ADDR_W(3), .DATA_W(8), .SYNC_STAGES(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0, errors = 0;
  int n_wr = 0, n_done = 0, n_err = 0;
  logic [7:0] m_regs [8];
  logic       m_armed;
  logic [7:0] m_snap;
  typedef struct {
    logic [15:0] bits;
    int          n;
    int          lat;
    int          wr, done, err;
    logic [15:0] rx;
    logic [2:0]  a;
    logic [7:0]  d;
  } vec_t;
  vec_t tbl [14];
  always @(negedge clk) begin
    if (bus.reg_wr_vld) n_wr++;
    if (bus.rd_done) n_done++;
    if (bus.frame_err) n_err++;
  end
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask
  // lat=1 checks write-strobe latency at frame end, lat=2 checks first-miso latency at frame start
  task automatic frame(input logic [15:0] bits, input int n, input int lat, output logic [15:0] rx);
    rx = '0;
    @(negedge clk) bus.cs = 1'b0;
    if (lat == 2) begin
      wait_clk(2);
      check("miso_lat_early", bus.miso, 0);
      wait_clk(1);
      check("miso_lat", bus.miso, 1);
      wait_clk(3);
    end else wait_clk(6);
    for (int i = 0; i < n; i++) begin
      bus.mosi = bits[n-1-i];
      wait_clk(6);
      rx[n-1-i] = bus.miso;
      bus.sclk = 1'b1;
      wait_clk(6);
      bus.sclk = 1'b0;
    end
    wait_clk(6);
    bus.cs = 1'b1;
    if (lat == 1) begin
      wait_clk(2);
      check("wr_lat_early", bus.reg_wr_vld, 0);
      wait_clk(1);
      check("wr_lat", bus.reg_wr_vld, 1);
      wait_clk(5);
    end else wait_clk(8);
  endtask
  task automatic apply(input string name, input logic [15:0] bits, input int n, input int lat,
                       input int e_wr, input int e_done, input int e_err, input logic [15:0] e_rx,
                       input logic [2:0] e_a, input logic [7:0] e_d);
    int w0, d0, r0;
    logic [15:0] rx;
    w0 = n_wr; d0 = n_done; r0 = n_err;
    frame(bits, n, lat, rx);
    check({name, "_wr_vld"}, n_wr - w0, e_wr);
    check({name, "_rd_done"}, n_done - d0, e_done);
    check({name, "_frame_err"}, n_err - r0, e_err);
    check({name, "_miso"}, rx, e_rx);
    if (e_wr != 0) begin
      check({name, "_wr_addr"}, bus.reg_wr_addr, e_a);
      check({name, "_wr_data"}, bus.reg_wr_data, e_d);
    end
  endtask
  // Frame-level model: decides the outcome of a whole cs-low frame from its length and contents.
  task automatic model_frame(input string name, input logic [15:0] bits, input int n);
    int e_wr, e_done, e_err;
    logic [15:0] e_rx;
    logic [2:0] e_a;
    logic [7:0] e_d;
    e_wr = 0; e_done = 0; e_err = 0; e_rx = '0; e_a = '0; e_d = '0;
    if (m_armed) begin
      for (int i = 0; i < n && i < 8; i++) e_rx[n-1-i] = m_snap[7-i];
      e_done = n >= 8 ? 1 : 0;
      e_err = n != 8 ? 1 : 0;
      m_armed = 1'b0;
    end else if (n == 12 && bits[11]) begin
      e_wr = 1;
      e_a = bits[10:8];
      e_d = bits[7:0];
      m_regs[e_a] = e_d;
    end else if (n == 4 && !bits[3]) begin
      m_armed = 1'b1;
      m_snap = m_regs[bits[2:0]];
    end else e_err = 1;
    apply(name, bits, n, 0, e_wr, e_done, e_err, e_rx, e_a, e_d);
  endtask
  initial begin
    int w0, r0, n;
    logic [15:0] bits, rx;
    bus.sclk = 1'b0; bus.cs = 1'b1; bus.mosi = 1'b0;
    tbl[0]  = '{16'h0BA5, 12, 1, 1, 0, 0, 16'h0000, 3'd3, 8'hA5};
    tbl[1]  = '{16'h0003,  4, 0, 0, 0, 0, 16'h0000, 3'd0, 8'h00};
    tbl[2]  = '{16'h0000,  8, 2, 0, 1, 0, 16'h00A5, 3'd0, 8'h00};
    tbl[3]  = '{16'h0005,  4, 0, 0, 0, 0, 16'h0000, 3'd0, 8'h00};
    tbl[4]  = '{16'h0DFF, 12, 0, 0, 1, 1, 16'h0000, 3'd0, 8'h00};
    tbl[5]  = '{16'h0005,  4, 0, 0, 0, 0, 16'h0000, 3'd0, 8'h00};
    tbl[6]  = '{16'h0000,  8, 0, 0, 1, 0, 16'h0000, 3'd0, 8'h00};
    tbl[7]  = '{16'h004A,  7, 0, 0, 0, 1, 16'h0000, 3'd0, 8'h00};
    tbl[8]  = '{16'h095A, 12, 0, 1, 0, 0, 16'h0000, 3'd1, 8'h5A};
    tbl[9]  = '{16'h15E1, 13, 0, 0, 0, 1, 16'h0000, 3'd0, 8'h00};
    tbl[10] = '{16'h0002,  4, 0, 0, 0, 0, 16'h0000, 3'd0, 8'h00};
    tbl[11] = '{16'h0000,  8, 0, 0, 1, 0, 16'h0000, 3'd0, 8'h00};
    tbl[12] = '{16'h0003,  4, 0, 0, 0, 0, 16'h0000, 3'd0, 8'h00};
    tbl[13] = '{16'h0000,  8, 0, 0, 1, 0, 16'h00A5, 3'd0, 8'h00};
    wait_clk(4);
    check("rst_miso", bus.miso, 0);
    check("rst_wr_vld", bus.reg_wr_vld, 0);
    check("rst_wr_addr", bus.reg_wr_addr, 0);
    check("rst_wr_data", bus.reg_wr_data, 0);
    check("rst_rd_done", bus.rd_done, 0);
    check("rst_frame_err", bus.frame_err, 0);
    rst = 1'b0;
    wait_clk(4);
    for (int i = 0; i < 14; i++)
      apply($sformatf("vec%0d", i), tbl[i].bits, tbl[i].n, tbl[i].lat, tbl[i].wr, tbl[i].done,
            tbl[i].err, tbl[i].rx, tbl[i].a, tbl[i].d);
    w0 = n_wr; r0 = n_err;
    bits = 16'h0B0F;
    @(negedge clk) bus.cs = 1'b0;
    wait_clk(6);
    for (int i = 0; i < 12; i++) begin
      bus.mosi = bits[11-i];
      wait_clk(6);
      bus.sclk = 1'b1;
      if (i == 11) bus.cs = 1'b1;
      wait_clk(6);
      bus.sclk = 1'b0;
    end
    wait_clk(8);
    check("coincident_wr_vld", n_wr - w0, 0);
    check("coincident_frame_err", n_err - r0, 1);
    bits = 16'h0FFF;
    @(negedge clk) bus.cs = 1'b0;
    wait_clk(6);
    for (int i = 0; i < 6; i++) begin
      bus.mosi = bits[11-i];
      wait_clk(6);
      bus.sclk = 1'b1;
      wait_clk(6);
      bus.sclk = 1'b0;
    end
    w0 = n_wr; r0 = n_err;
    rst = 1'b1;
    wait_clk(3);
    bus.cs = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(10);
    check("midrst_wr_vld", n_wr - w0, 0);
    check("midrst_frame_err", n_err - r0, 0);
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_armed = 1'b0;
    m_snap = 8'h00;
    model_frame("midrst_wr", 16'h083C, 12);
    model_frame("midrst_rdaddr", 16'h0000, 4);
    apply("midrst_rddata", 16'h0000, 8, 0, 0, 1, 0, 16'h003C, 3'd0, 8'h00);
    m_armed = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (m_armed) begin
        n = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 12)) : 8;
        bits = 16'($urandom);
      end else begin
        case ($urandom_range(0, 3))
          0, 1: begin n = 12; bits = {4'h0, 1'b1, 11'($urandom)}; end
          2: begin n = 4; bits = {12'h000, 1'b0, 3'($urandom)}; end
          default: begin n = $urandom_range(0, 13); bits = 16'($urandom); end
        endcase
      end
      for (int b = n; b < 16; b++) bits[b] = 1'b0;
      model_frame($sformatf("rnd%0d", k), bits, n);
    end
    rx = '0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
